// File: rtl/next_pc_pkg.sv
// Shared definitions for the fetch-stage next-PC logic: npc_sel encodings,
// default reset/exception addresses (also used by CP0 and the bench) and
// the two-state pending-redirect FSM type.
package next_pc_pkg;

  localparam logic [2:0] NPC_SEQ  = 3'd0;
  localparam logic [2:0] NPC_BR   = 3'd1;
  localparam logic [2:0] NPC_J    = 3'd2;
  localparam logic [2:0] NPC_JR   = 3'd3;
  localparam logic [2:0] NPC_ERET = 3'd4;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

  // IDLE: no buffered redirect. PEND: pend_target holds a redirect waiting
  // for the instruction memory to accept a new address.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } npc_state_t;

  // Force a fetch address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/npc_target.sv
// Purely combinational redirect target computation from the decode-stage PC.
// Reports whether the raw target is misaligned; alignment itself is applied
// by the caller when the target is stored.
module npc_target
  import next_pc_pkg::*;
(
  input  logic [31:0] pc_d,
  input  logic [2:0]  npc_sel,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  input  logic [31:0] epc,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] base;
  logic [31:0] br_off;

  assign base   = pc_d + 32'd4;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  // Select the raw target for the decoded control-transfer kind.
  always_comb begin
    target = base;
    unique case (npc_sel)
      NPC_BR:   target = base + br_off;
      NPC_J:    target = {base[31:28], imm26, 2'b00};
      NPC_JR:   target = rs_val;
      NPC_ERET: target = epc;
      default:  target = base;
    endcase
  end

  assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/next_pc_unit.sv
// Fetch-stage PC register with exception, stall, redirect and IM-handshake
// arbitration, plus a one-entry buffer for redirects that arrive while the
// instruction memory is not ready.
//
// Build option NEXT_PC_DELAY_SLOT_EN: when defined, MIPS delay-slot
// behaviour (link = pc_d+8, flush_f tied low). When undefined, no delay
// slot (link = pc_d+4, flush_f squashes the fall-through on redirect).
//
// Handshake: fetch_ready is a ready-only acceptance of the current pc; the
// pc register may move to a non-exception address only on an edge where
// fetch_ready is high. exc_req overrides the handshake unconditionally.
module next_pc_unit
  import next_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic [31:0] pc_d,
  input  logic [2:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  input  logic [31:0] epc,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        redirect_pending,
  output logic        addr_err,
  output logic        flush_f
);

  npc_state_t  state_q, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] pend_q, pend_nxt;
  logic        addr_err_q, addr_err_nxt;

  logic [31:0] target;
  logic        misaligned;
  logic        redirect;

  npc_target u_target (
    .pc_d       (pc_d),
    .npc_sel    (npc_sel),
    .imm16      (imm16),
    .imm26      (imm26),
    .rs_val     (rs_val),
    .epc        (epc),
    .target     (target),
    .misaligned (misaligned)
  );

  // A stalled decode instruction is not trustworthy, so it never redirects.
  always_comb begin
    redirect = 1'b0;
    if (!stall) begin
      unique case (npc_sel)
        NPC_BR:                    redirect = br_taken;
        NPC_J, NPC_JR, NPC_ERET:   redirect = 1'b1;
        default:                   redirect = 1'b0;
      endcase
    end
  end

  // Next-state and next-PC priority: exception, stall, redirect, pending, sequential.
  always_comb begin
    state_nxt    = state_q;
    pc_nxt       = pc_q;
    pend_nxt     = pend_q;
    addr_err_nxt = 1'b0;
    if (exc_req) begin
      pc_nxt    = EXC_VECTOR;
      state_nxt = ST_IDLE;
    end else if (stall) begin
      state_nxt = state_q;
    end else if (redirect && fetch_ready) begin
      pc_nxt       = word_align(target);
      state_nxt    = ST_IDLE;
      addr_err_nxt = misaligned;
    end else if (redirect) begin
      // A newer redirect simply replaces any older buffered one.
      pend_nxt     = word_align(target);
      state_nxt    = ST_PEND;
      addr_err_nxt = misaligned;
    end else if ((state_q == ST_PEND) && fetch_ready) begin
      pc_nxt    = pend_q;
      state_nxt = ST_IDLE;
    end else if (fetch_ready) begin
      pc_nxt = pc_q + 32'd4;
    end
  end

  // State, PC, pending buffer and error pulse registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= 32'd0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      pc_q       <= pc_nxt;
      pend_q     <= pend_nxt;
      addr_err_q <= addr_err_nxt;
    end
  end

  assign pc               = pc_q;
  assign redirect_pending = (state_q == ST_PEND);
  assign addr_err         = addr_err_q;

`ifdef NEXT_PC_DELAY_SLOT_EN
  assign link_addr = pc_d + 32'd8;
  assign flush_f   = 1'b0;
`else
  assign link_addr = pc_d + 32'd4;
  // Redirect accepted (taken directly or buffered) squashes the fall-through.
  assign flush_f   = redirect && !exc_req;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: reset, sequential fetch, branches, jumps,
// buffered redirects, exception precedence, misalignment, wrap and both
// delay-slot build variants.
module tb_next_pc_unit;
  import next_pc_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        fetch_ready;
  logic [31:0] pc_d;
  logic [2:0]  npc_sel;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_val;
  logic [31:0] epc;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        redirect_pending;
  logic        addr_err;
  logic        flush_f;

  int tests;
  int fails;

  next_pc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .fetch_ready      (fetch_ready),
    .pc_d             (pc_d),
    .npc_sel          (npc_sel),
    .br_taken         (br_taken),
    .imm16            (imm16),
    .imm26            (imm26),
    .rs_val           (rs_val),
    .epc              (epc),
    .exc_req          (exc_req),
    .pc               (pc),
    .link_addr        (link_addr),
    .redirect_pending (redirect_pending),
    .addr_err         (addr_err),
    .flush_f          (flush_f)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] exp_pc,
                             input logic exp_pend, input logic exp_err);
    check({tag, ".pc"}, pc, exp_pc);
    check({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, exp_pend});
    check({tag, ".aerr"}, {31'd0, addr_err}, {31'd0, exp_err});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0; stall = 1'b0; fetch_ready = 1'b0; pc_d = 32'd0;
    npc_sel = NPC_SEQ; br_taken = 1'b0; imm16 = 16'd0; imm26 = 26'd0;
    rs_val = 32'd0; epc = 32'd0; exc_req = 1'b0;

    // Reset held two edges
    step(); step();
    check_state("reset", 32'h0000_3000, 1'b0, 1'b0);

    // Release with fetch_ready: sequential fetch
    reset = 1'b1; fetch_ready = 1'b1;
    step(); check_state("seq1", 32'h0000_3004, 1'b0, 1'b0);
    step(); check_state("seq2", 32'h0000_3008, 1'b0, 1'b0);

    // Branch taken backwards: 3014 - 16 = 3004
    npc_sel = NPC_BR; pc_d = 32'h0000_3010; imm16 = 16'hFFFC; br_taken = 1'b1;
    step(); check_state("br_taken", 32'h0000_3004, 1'b0, 1'b0);
    br_taken = 1'b0;
    step(); check_state("br_not_taken", 32'h0000_3008, 1'b0, 1'b0);

    // Branch taken while stalled: pc held
    br_taken = 1'b1; stall = 1'b1;
    step(); check_state("br_stall", 32'h0000_3008, 1'b0, 1'b0);
    stall = 1'b0;

    // Reserved select value behaves as sequential
    npc_sel = 3'd5;
    step(); check_state("sel5_seq", 32'h0000_300C, 1'b0, 1'b0);

    // Buffered J while IM busy for three cycles
    npc_sel = NPC_J; pc_d = 32'h0000_3020; imm26 = 26'h0000C40; fetch_ready = 1'b0;
    step(); check_state("j_pend1", 32'h0000_300C, 1'b1, 1'b0);
    npc_sel = NPC_SEQ;
    step(); check_state("j_pend2", 32'h0000_300C, 1'b1, 1'b0);
    step(); check_state("j_pend3", 32'h0000_300C, 1'b1, 1'b0);
    // Stall holds the pending redirect even with IM ready
    stall = 1'b1; fetch_ready = 1'b1;
    step(); check_state("j_pend_stall", 32'h0000_300C, 1'b1, 1'b0);
    stall = 1'b0;
    step(); check_state("j_release", 32'h0000_3100, 1'b0, 1'b0);

    // Newer redirect overwrites older pending one
    fetch_ready = 1'b0; npc_sel = NPC_JR; rs_val = 32'h0000_3200;
    step(); check_state("ovw1", 32'h0000_3100, 1'b1, 1'b0);
    rs_val = 32'h0000_3300;
    step(); check_state("ovw2", 32'h0000_3100, 1'b1, 1'b0);
    npc_sel = NPC_SEQ; fetch_ready = 1'b1;
    step(); check_state("ovw_release", 32'h0000_3300, 1'b0, 1'b0);

    // Exception beats stall, pending JR and busy IM
    fetch_ready = 1'b0; npc_sel = NPC_JR; rs_val = 32'h0000_3200;
    step(); check_state("exc_setup", 32'h0000_3300, 1'b1, 1'b0);
    exc_req = 1'b1; stall = 1'b1;
    step(); check_state("exc", 32'h0000_4180, 1'b0, 1'b0);
    exc_req = 1'b0; stall = 1'b0; npc_sel = NPC_SEQ; fetch_ready = 1'b1;
    step(); check_state("post_exc", 32'h0000_4184, 1'b0, 1'b0);

    // Misaligned JR taken directly: aligned pc, one-cycle addr_err
    npc_sel = NPC_JR; rs_val = 32'h0000_3006;
    step(); check_state("mis_jr", 32'h0000_3004, 1'b0, 1'b1);
    npc_sel = NPC_SEQ;
    step(); check_state("mis_jr_next", 32'h0000_3008, 1'b0, 1'b0);

    // Misaligned JR buffered: pulse on the buffering edge, aligned release
    npc_sel = NPC_JR; rs_val = 32'h0000_3207; fetch_ready = 1'b0;
    step(); check_state("mis_pend", 32'h0000_3008, 1'b1, 1'b1);
    npc_sel = NPC_SEQ; fetch_ready = 1'b1;
    step(); check_state("mis_release", 32'h0000_3204, 1'b0, 1'b0);

    // Wrap at the top of the address space
    npc_sel = NPC_JR; rs_val = 32'hFFFF_FFFC;
    step(); check_state("wrap_top", 32'hFFFF_FFFC, 1'b0, 1'b0);
    npc_sel = NPC_SEQ;
    step(); check_state("wrap_zero", 32'h0000_0000, 1'b0, 1'b0);

    // ERET
    npc_sel = NPC_ERET; epc = 32'h0000_3040;
    step(); check_state("eret", 32'h0000_3040, 1'b0, 1'b0);

    // jal link address and flush (combinational)
    npc_sel = NPC_J; pc_d = 32'h0000_3000; imm26 = 26'h0000C00;
    #1;
`ifdef NEXT_PC_DELAY_SLOT_EN
    check("link_jal", link_addr, 32'h0000_3008);
    check("flush_jal", {31'd0, flush_f}, 32'd0);
`else
    check("link_jal", link_addr, 32'h0000_3004);
    check("flush_jal", {31'd0, flush_f}, 32'd1);
`endif
    stall = 1'b1;
    #1;
    check("flush_stalled", {31'd0, flush_f}, 32'd0);
    npc_sel = NPC_SEQ;
    #1;
    check("flush_seq", {31'd0, flush_f}, 32'd0);
    stall = 1'b0;

    // Reset while pending discards the buffered target
    npc_sel = NPC_JR; rs_val = 32'h0000_3500; fetch_ready = 1'b0;
    step(); check_state("rst_pend_setup", 32'h0000_3040, 1'b1, 1'b0);
    reset = 1'b0; npc_sel = NPC_SEQ;
    step(); check_state("rst_mid_pend", 32'h0000_3000, 1'b0, 1'b0);
    reset = 1'b1; fetch_ready = 1'b1;
    step(); check_state("rst_after", 32'h0000_3004, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
